// File: rtl/h264mbsched_if.sv
// Scheduler-side bundle for h264mbsched: frame control, header handshake,
// buffer feedback and macroblock issue signals. Suffixes are relative to
// the scheduler (_i = into the scheduler, _o = driven by the scheduler).
//   master : frame controller / header / buffer / pipeline side
//   slave  : the scheduler itself
interface h264mbsched_if;
  logic       start_i;      // frame start request
  logic       abort_i;      // synchronous abort
  logic       hdr_done_i;   // header finished (pulse)
  logic       nxinc_i;      // buffer retired one macroblock (pulse)
  logic       buf_done_i;   // buffer quiescent
  logic       hdr_req_o;    // header may be emitted (level)
  logic       newslice_o;   // slice start pulse
  logic       newline_o;    // output-row boundary pulse
  logic       mb_start_o;   // macroblock issue pulse
  logic [7:0] mbx_o;        // issued macroblock column
  logic [7:0] mby_o;        // issued macroblock row
  logic       busy_o;       // not idle
  logic       frame_done_o; // frame complete pulse
  logic       err_o;        // sticky spurious-retire flag

  modport master (
    output start_i, abort_i, hdr_done_i, nxinc_i, buf_done_i,
    input  hdr_req_o, newslice_o, newline_o, mb_start_o, mbx_o, mby_o,
           busy_o, frame_done_o, err_o
  );

  modport slave (
    input  start_i, abort_i, hdr_done_i, nxinc_i, buf_done_i,
    output hdr_req_o, newslice_o, newline_o, mb_start_o, mbx_o, mby_o,
           busy_o, frame_done_o, err_o
  );
endinterface

// File: rtl/h264mbsched.sv
// Frame-level macroblock scheduler: runs one frame as a single slice.
// Requests the slice header, pulses NEWSLICE, issues macroblocks to the
// prediction/transform pipeline under an in-flight credit limit, tracks
// retired macroblocks to pulse NEWLINE at output-row boundaries, and waits
// for the buffer to drain before pulsing FRAME_DONE.
// Ports:
//   CLK, RESETN : clock, asynchronous active-low reset
//   bus         : h264mbsched_if.slave (control inputs, registered outputs)
module h264mbsched #(
  parameter int unsigned WIDTH_MB     = 20,
  parameter int unsigned HEIGHT_MB    = 15,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic          CLK,
  input  logic          RESETN,
  h264mbsched_if.slave  bus
);

  localparam int unsigned CW = 8;
  localparam int unsigned IW = 2;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_IDLE  = 3'd0;
  localparam logic [SW-1:0] S_HDR   = 3'd1;
  localparam logic [SW-1:0] S_SLICE = 3'd2;
  localparam logic [SW-1:0] S_ISSUE = 3'd3;
  localparam logic [SW-1:0] S_FLUSH = 3'd4;
  localparam logic [SW-1:0] S_FDONE = 3'd5;

  localparam logic [CW-1:0] X_LAST  = CW'(WIDTH_MB - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(HEIGHT_MB - 1);
  localparam logic [IW-1:0] INF_MAX = IW'(MAX_INFLIGHT);

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] mbx_q, mbx_d, mby_q, mby_d;
  logic [CW-1:0] ocol_q, ocol_d, orow_q, orow_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          hdr_req_q, hdr_req_d;
  logic          newslice_q, newslice_d;
  logic          newline_q, newline_d;
  logic          mb_start_q, mb_start_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;

  logic          nx_valid;
  logic          nx_spur;
  logic [IW-1:0] inflight_eff;

  // A retire with nothing in flight is dropped and flagged.
  assign nx_valid = bus.nxinc_i && (inflight_q != '0);
  assign nx_spur  = bus.nxinc_i && (inflight_q == '0);

  // In-flight count after this cycle's issue pulse and retire; an issue
  // and a retire in the same cycle cancel.
  always_comb begin
    inflight_eff = inflight_q;
    if (mb_start_q && !nx_valid) begin
      inflight_eff = inflight_q + IW'(1);
    end else if (!mb_start_q && nx_valid) begin
      inflight_eff = inflight_q - IW'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mbx_d        = mbx_q;
    mby_d        = mby_q;
    ocol_d       = ocol_q;
    orow_d       = orow_q;
    inflight_d   = inflight_eff;
    hdr_req_d    = hdr_req_q;
    newslice_d   = 1'b0;
    newline_d    = 1'b0;
    mb_start_d   = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q | nx_spur;

    // Output-side position; NEWLINE lands the cycle after the retire so it
    // never overlaps the retire that caused it. No NEWLINE for the last row.
    if (nx_valid) begin
      if (ocol_q == X_LAST) begin
        ocol_d    = '0;
        orow_d    = orow_q + CW'(1);
        newline_d = (orow_q != Y_LAST);
      end else begin
        ocol_d    = ocol_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d   = S_HDR;
          hdr_req_d = 1'b1;
          err_d     = 1'b0;
        end
      end
      S_HDR: begin
        if (bus.hdr_done_i) begin
          state_d    = S_SLICE;
          hdr_req_d  = 1'b0;
          newslice_d = 1'b1;
          mbx_d      = '0;
          mby_d      = '0;
          ocol_d     = '0;
          orow_d     = '0;
          inflight_d = '0;
          newline_d  = 1'b0;
        end
      end
      S_SLICE: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // The cycle after a pulse advances the position, which also
        // guarantees an idle cycle between issues.
        if (mb_start_q) begin
          if (mbx_q == X_LAST) begin
            mbx_d = '0;
            mby_d = mby_q + CW'(1);
            if (mby_q == Y_LAST) begin
              state_d = S_FLUSH;
            end
          end else begin
            mbx_d = mbx_q + CW'(1);
          end
        end else if (inflight_eff < INF_MAX) begin
          mb_start_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if ((inflight_eff == '0) && bus.buf_done_i) begin
          state_d      = S_FDONE;
          frame_done_d = 1'b1;
        end
      end
      S_FDONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a coincident START; ERR survives.
    if (bus.abort_i) begin
      state_d      = S_IDLE;
      mbx_d        = '0;
      mby_d        = '0;
      ocol_d       = '0;
      orow_d       = '0;
      inflight_d   = '0;
      hdr_req_d    = 1'b0;
      newslice_d   = 1'b0;
      newline_d    = 1'b0;
      mb_start_d   = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_q | nx_spur;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= S_IDLE;
      mbx_q        <= '0;
      mby_q        <= '0;
      ocol_q       <= '0;
      orow_q       <= '0;
      inflight_q   <= '0;
      hdr_req_q    <= 1'b0;
      newslice_q   <= 1'b0;
      newline_q    <= 1'b0;
      mb_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mbx_q        <= mbx_d;
      mby_q        <= mby_d;
      ocol_q       <= ocol_d;
      orow_q       <= orow_d;
      inflight_q   <= inflight_d;
      hdr_req_q    <= hdr_req_d;
      newslice_q   <= newslice_d;
      newline_q    <= newline_d;
      mb_start_q   <= mb_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.hdr_req_o    = hdr_req_q;
  assign bus.newslice_o   = newslice_q;
  assign bus.newline_o    = newline_q;
  assign bus.mb_start_o   = mb_start_q;
  assign bus.mbx_o        = mbx_q;
  assign bus.mby_o        = mby_q;
  assign bus.busy_o       = busy_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_h264mbsched.sv
// Directed bench for h264mbsched: three instances (2x2 credit 2, 2x2
// credit 1, 1x3 credit 2) selected one at a time; a responder retires each
// issued macroblock a fixed number of cycles later, a monitor logs pulse
// cycles, and the checks compare them with hand-derived cycle offsets.
module tb_h264mbsched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int   sel = 0;
  logic st = 1'b0, ab = 1'b0, hd = 1'b0, bd = 1'b0, nx = 1'b0, nx_man = 1'b0;
  int   resp_dly = 20;
  logic resp_en  = 1'b0;

  h264mbsched_if if_a ();
  h264mbsched_if if_b ();
  h264mbsched_if if_c ();

  h264mbsched #(.WIDTH_MB(2), .HEIGHT_MB(2), .MAX_INFLIGHT(2)) u_a (.CLK(clk), .RESETN(rst_n), .bus(if_a));
  h264mbsched #(.WIDTH_MB(2), .HEIGHT_MB(2), .MAX_INFLIGHT(1)) u_b (.CLK(clk), .RESETN(rst_n), .bus(if_b));
  h264mbsched #(.WIDTH_MB(1), .HEIGHT_MB(3), .MAX_INFLIGHT(2)) u_c (.CLK(clk), .RESETN(rst_n), .bus(if_c));

  assign if_a.start_i    = (sel == 0) && st;
  assign if_a.abort_i    = (sel == 0) && ab;
  assign if_a.hdr_done_i = (sel == 0) && hd;
  assign if_a.buf_done_i = (sel == 0) && bd;
  assign if_a.nxinc_i    = (sel == 0) && nx;
  assign if_b.start_i    = (sel == 1) && st;
  assign if_b.abort_i    = (sel == 1) && ab;
  assign if_b.hdr_done_i = (sel == 1) && hd;
  assign if_b.buf_done_i = (sel == 1) && bd;
  assign if_b.nxinc_i    = (sel == 1) && nx;
  assign if_c.start_i    = (sel == 2) && st;
  assign if_c.abort_i    = (sel == 2) && ab;
  assign if_c.hdr_done_i = (sel == 2) && hd;
  assign if_c.buf_done_i = (sel == 2) && bd;
  assign if_c.nxinc_i    = (sel == 2) && nx;

  // Outputs of the selected instance: {hdr,ns,nl,mbs,busy,fd,err,x,y}
  logic [22:0] m_vec;
  always_comb begin
    case (sel)
      1: m_vec = {if_b.hdr_req_o, if_b.newslice_o, if_b.newline_o, if_b.mb_start_o,
                  if_b.busy_o, if_b.frame_done_o, if_b.err_o, if_b.mbx_o, if_b.mby_o};
      2: m_vec = {if_c.hdr_req_o, if_c.newslice_o, if_c.newline_o, if_c.mb_start_o,
                  if_c.busy_o, if_c.frame_done_o, if_c.err_o, if_c.mbx_o, if_c.mby_o};
      default: m_vec = {if_a.hdr_req_o, if_a.newslice_o, if_a.newline_o, if_a.mb_start_o,
                        if_a.busy_o, if_a.frame_done_o, if_a.err_o, if_a.mbx_o, if_a.mby_o};
    endcase
  end

  logic       m_hdr, m_ns, m_nl, m_mbs, m_busy, m_fd, m_err;
  logic [7:0] m_x, m_y;
  assign {m_hdr, m_ns, m_nl, m_mbs, m_busy, m_fd, m_err, m_x, m_y} = m_vec;

  int mb_cyc[$], mb_x[$], mb_y[$], nl_cyc[$], fd_cyc[$];
  int hdr_n = 0, ns_n = 0;

  always @(negedge clk) begin
    if (m_hdr) hdr_n++;
    if (m_ns)  ns_n++;
    if (m_mbs) begin
      mb_cyc.push_back(cyc);
      mb_x.push_back(int'(m_x));
      mb_y.push_back(int'(m_y));
    end
    if (m_nl) nl_cyc.push_back(cyc);
    if (m_fd) fd_cyc.push_back(cyc);
  end

  // Buffer model: retire each issued macroblock resp_dly cycles after its pulse.
  int due[$];
  always @(posedge clk) begin
    logic hit;
    #2;
    hit = 1'b0;
    if (resp_en && m_mbs) due.push_back(cyc + resp_dly);
    while (due.size() > 0 && due[0] < cyc) void'(due.pop_front());
    if (due.size() > 0 && due[0] == cyc) begin
      hit = 1'b1;
      void'(due.pop_front());
    end
    nx = nx_man | (hit & resp_en);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    mb_cyc.delete(); mb_x.delete(); mb_y.delete();
    nl_cyc.delete(); fd_cyc.delete();
    hdr_n = 0; ns_n = 0;
  endtask

  // Starts a frame at cycle s; HDR_DONE arrives at s+3.
  task automatic begin_frame(output int s);
    s = cyc; st = 1'b1; step(1); st = 1'b0; step(2); hd = 1'b1; step(1); hd = 1'b0;
  endtask

  int e_off[4], e_x[4], e_y[4], e_nl[2];

  task automatic run_frame(input string nm, input int dly, input int nmb,
                           input int fd_off, input int nnl, input int bound);
    int s;
    clear_logs(); resp_dly = dly; resp_en = 1'b1; bd = 1'b1;
    begin_frame(s);
    for (int i = 0; i < bound && fd_cyc.size() == 0; i++) step(1);
    step(2);
    check_eq($sformatf("%s_hdr_cycles", nm), hdr_n, 3);
    check_eq($sformatf("%s_newslice", nm), ns_n, 1);
    check_eq($sformatf("%s_mb_count", nm), mb_cyc.size(), nmb);
    for (int i = 0; i < nmb; i++) begin
      check_eq($sformatf("%s_mb%0d_cyc", nm, i), (i < mb_cyc.size()) ? mb_cyc[i] - s : -1, e_off[i]);
      check_eq($sformatf("%s_mb%0d_x", nm, i), (i < mb_x.size()) ? mb_x[i] : -1, e_x[i]);
      check_eq($sformatf("%s_mb%0d_y", nm, i), (i < mb_y.size()) ? mb_y[i] : -1, e_y[i]);
    end
    check_eq($sformatf("%s_fd_count", nm), fd_cyc.size(), 1);
    check_eq($sformatf("%s_fd_cyc", nm), (fd_cyc.size() > 0) ? fd_cyc[0] - s : -1, fd_off);
    check_eq($sformatf("%s_nl_count", nm), nl_cyc.size(), nnl);
    for (int i = 0; i < nnl; i++)
      check_eq($sformatf("%s_nl%0d_cyc", nm, i), (i < nl_cyc.size()) ? nl_cyc[i] - s : -1, e_nl[i]);
    check_eq($sformatf("%s_busy_end", nm), m_busy, 0);
    check_eq($sformatf("%s_err_end", nm), m_err, 0);
  endtask

  initial begin
    int s;
    #1;
    check_eq("reset_outputs", m_vec, 0);
    step(2); rst_n = 1'b1; step(2);
    check_eq("idle_outputs", m_vec, 0);

    // 2x2, retire 20 cycles after each issue.
    e_off = '{6, 8, 27, 29}; e_x = '{0, 1, 0, 1}; e_y = '{0, 0, 1, 1}; e_nl = '{29, 0};
    run_frame("basic", 20, 4, 50, 1, 200);
    step(3);

    // Each retire coincides with the next issue: count holds, one idle cycle between issues.
    e_off = '{6, 8, 10, 12}; e_nl = '{11, 0};
    run_frame("coinc", 2, 4, 15, 1, 100);
    step(3);

    // Abort after the third issue.
    clear_logs(); resp_dly = 2; resp_en = 1'b1; bd = 1'b1;
    begin_frame(s);
    step(7);
    check_eq("abort_pre_mbs", mb_cyc.size(), 3);
    ab = 1'b1; resp_en = 1'b0; step(1); ab = 1'b0;
    check_eq("abort_busy", m_busy, 0);
    check_eq("abort_hdr_mbs", {m_hdr, m_mbs}, 0);
    step(30);
    check_eq("abort_mbs", mb_cyc.size(), 3);
    check_eq("abort_no_fd", fd_cyc.size(), 0);
    check_eq("abort_err", m_err, 0);
    e_off = '{6, 8, 27, 29}; e_x = '{0, 1, 0, 1}; e_y = '{0, 0, 1, 1}; e_nl = '{29, 0};
    run_frame("post_abort", 20, 4, 50, 1, 200);
    step(3);

    // Credit 1, retire withheld 50 cycles: next issue one cycle after retire.
    sel = 1; step(2);
    e_off = '{6, 57, 108, 159}; e_nl = '{108, 0};
    run_frame("credit1", 50, 4, 210, 1, 400);
    step(3);

    // Single-column frame of three rows.
    sel = 2; step(2);
    e_off = '{6, 8, 27, 0}; e_x = '{0, 0, 0, 0}; e_y = '{0, 1, 2, 0}; e_nl = '{27, 29};
    run_frame("w1", 20, 3, 48, 2, 200);
    step(3);

    // Spurious retire in FLUSH, then reset mid-FLUSH.
    sel = 0; step(2);
    clear_logs(); resp_dly = 2; resp_en = 1'b1; bd = 1'b0;
    begin_frame(s);
    step(11);
    check_eq("spur_err_before", m_err, 0);
    nx_man = 1'b1; step(1); nx_man = 1'b0;
    check_eq("spur_err_after", m_err, 1);
    check_eq("spur_busy_flush", m_busy, 1);
    check_eq("spur_no_fd", fd_cyc.size(), 0);
    rst_n = 1'b0; #1;
    check_eq("midflush_reset_outputs", m_vec, 0);
    step(2); rst_n = 1'b1; step(10);
    check_eq("post_reset_outputs", m_vec, 0);
    check_eq("post_reset_mbs", mb_cyc.size(), 4);
    check_eq("post_reset_fd", fd_cyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
